// File: rtl/exec_seq_ctrl_pkg.sv
// exec_seq_ctrl_pkg
//   Shared Y86-64 execute-stage definitions: instruction codes, ALU function
//   codes, jXX/cmovXX condition codes, sequencer states, CC bit positions
//   and the legality check used at instruction accept.
package exec_seq_ctrl_pkg;

   localparam int         DATA_W     = 64;
   localparam logic [2:0] CC_RST_DEF = 3'b001;   // {OF,SF,ZF}: ZF=1

   // Instruction codes
   localparam logic [3:0] ICODE_HALT   = 4'h0;
   localparam logic [3:0] ICODE_NOP    = 4'h1;
   localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
   localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
   localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
   localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
   localparam logic [3:0] ICODE_OPQ    = 4'h6;
   localparam logic [3:0] ICODE_JXX    = 4'h7;
   localparam logic [3:0] ICODE_CALL   = 4'h8;
   localparam logic [3:0] ICODE_RET    = 4'h9;
   localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
   localparam logic [3:0] ICODE_POPQ   = 4'hB;

   // ALU functions (SUB computes b - a)
   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_AND = 2'd2;
   localparam logic [1:0] ALU_XOR = 2'd3;

   // Condition codes carried in ifun for jXX/cmovXX
   localparam logic [3:0] C_ALWAYS = 4'd0;
   localparam logic [3:0] C_LE     = 4'd1;
   localparam logic [3:0] C_L      = 4'd2;
   localparam logic [3:0] C_E      = 4'd3;
   localparam logic [3:0] C_NE     = 4'd4;
   localparam logic [3:0] C_GE     = 4'd5;
   localparam logic [3:0] C_G      = 4'd6;

   // CC bit indices
   localparam int CC_ZF = 0;
   localparam int CC_SF = 1;
   localparam int CC_OF = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_CAPT  = 2'd2
   } state_t;

   // cond_ill is the condition decoder's verdict on ifun; it only matters for
   // the two icodes that interpret ifun as a condition.
   function automatic logic instr_illegal(input logic [3:0] icode,
                                          input logic [3:0] ifun,
                                          input logic       cond_ill);
      logic ill;
      ill = 1'b0;
      if (icode > ICODE_POPQ)
         ill = 1'b1;
      else if (icode == ICODE_OPQ && ifun > 4'd3)
         ill = 1'b1;
      else if ((icode == ICODE_RRMOVQ || icode == ICODE_JXX) && cond_ill)
         ill = 1'b1;
      return ill;
   endfunction

endpackage

// File: rtl/exec_seq_ctrl_cond.sv
// cond_eval
//   Purely combinational jXX/cmovXX condition evaluator.
//   cc      in  3  condition codes {OF,SF,ZF}
//   ifun    in  4  condition selector
//   cnd     out 1  condition result (0 when illegal)
//   illegal out 1  ifun is not a defined condition
module cond_eval
   import exec_seq_ctrl_pkg::*;
(
   input  logic [2:0] cc,
   input  logic [3:0] ifun,
   output logic       cnd,
   output logic       illegal
);

   logic zf, sf, of;
   assign zf = cc[CC_ZF];
   assign sf = cc[CC_SF];
   assign of = cc[CC_OF];

   always_comb begin
      cnd     = 1'b0;
      illegal = 1'b0;
      case (ifun)
         C_ALWAYS: cnd = 1'b1;
         C_LE:     cnd = (sf ^ of) | zf;
         C_L:      cnd = sf ^ of;
         C_E:      cnd = zf;
         C_NE:     cnd = ~zf;
         C_GE:     cnd = ~(sf ^ of);
         C_G:      cnd = ~(sf ^ of) & ~zf;
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/exec_seq_ctrl.sv
// exec_seq_ctrl
//   Y86-64 execute-stage sequencer. Accepts one decoded instruction per start,
//   drives the external ALU for one cycle (ISSUE), then captures valE, cnd and
//   the CC register (OPq only) in CAPT with a done pulse.
//   clk/rst_n            clock, synchronous active-low reset
//   start/busy           request / accept handshake
//   icode ifun valA valB valC   decoded instruction
//   alu_en alu_a alu_b alu_fun  ALU drive (only non-zero in ISSUE)
//   alu_out alu_cf              ALU result and flags {OF,SF,ZF}
//   valE cc cnd done err halt   results
module exec_seq_ctrl
   import exec_seq_ctrl_pkg::*;
#(
   parameter int         W      = DATA_W,
   parameter logic [2:0] CC_RST = CC_RST_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   output logic         busy,
   input  logic [3:0]   icode,
   input  logic [3:0]   ifun,
   input  logic [W-1:0] valA,
   input  logic [W-1:0] valB,
   input  logic [W-1:0] valC,
   output logic         alu_en,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [1:0]   alu_fun,
   input  logic [W-1:0] alu_out,
   input  logic [2:0]   alu_cf,
   output logic [W-1:0] valE,
   output logic [2:0]   cc,
   output logic         cnd,
   output logic         done,
   output logic         err,
   output logic         halt
);

   state_t         state_q;
   logic           busy_q, alu_en_q, done_q, err_q, halt_q, cnd_q;
   logic [W-1:0]   alu_a_q, alu_b_q, valE_q;
   logic [1:0]     alu_fun_q;
   logic [2:0]     cc_q;
   // Decisions made at accept and consumed at the ISSUE->CAPT edge
   logic           cnd_pend_q, ill_q, upd_cc_q, zero_e_q, is_halt_q;

   // The condition is resolved at accept: cc cannot change while this op is
   // in flight, so this equals "cc before this instruction's update".
   logic ce_cnd, ce_ill;
   cond_eval u_cond (
      .cc      (cc_q),
      .ifun    (ifun),
      .cnd     (ce_cnd),
      .illegal (ce_ill)
   );

   logic         ill_d, is_cond_d, cnd_d;
   logic [W-1:0] a_d, b_d;
   logic [1:0]   fun_d;

   assign ill_d     = instr_illegal(icode, ifun, ce_ill);
   assign is_cond_d = (icode == ICODE_RRMOVQ) || (icode == ICODE_JXX);
   assign cnd_d     = ill_d ? 1'b0 : (is_cond_d ? ce_cnd : 1'b1);

   // Operand mux; illegal instructions present all-zero operands.
   always_comb begin
      a_d   = '0;
      b_d   = '0;
      fun_d = ALU_ADD;
      if (!ill_d) begin
         case (icode)
            ICODE_RRMOVQ: a_d = valA;
            ICODE_OPQ: begin
               a_d   = valA;
               b_d   = valB;
               fun_d = ifun[1:0];
            end
            ICODE_IRMOVQ:                a_d = valC;
            ICODE_RMMOVQ, ICODE_MRMOVQ: begin
               a_d = valC;
               b_d = valB;
            end
            ICODE_CALL, ICODE_PUSHQ: begin
               a_d = -W'(8);
               b_d = valB;
            end
            ICODE_RET, ICODE_POPQ: begin
               a_d = W'(8);
               b_d = valB;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         alu_en_q   <= 1'b0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_fun_q  <= ALU_ADD;
         valE_q     <= '0;
         cc_q       <= CC_RST;
         cnd_q      <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         halt_q     <= 1'b0;
         cnd_pend_q <= 1'b0;
         ill_q      <= 1'b0;
         upd_cc_q   <= 1'b0;
         zero_e_q   <= 1'b0;
         is_halt_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !halt_q) begin
                  state_q    <= S_ISSUE;
                  busy_q     <= 1'b1;
                  alu_en_q   <= !ill_d;
                  alu_a_q    <= a_d;
                  alu_b_q    <= b_d;
                  alu_fun_q  <= fun_d;
                  cnd_pend_q <= cnd_d;
                  ill_q      <= ill_d;
                  upd_cc_q   <= !ill_d && (icode == ICODE_OPQ);
                  zero_e_q   <= ill_d || icode == ICODE_HALT || icode == ICODE_NOP;
                  is_halt_q  <= !ill_d && (icode == ICODE_HALT);
               end
            end
            S_ISSUE: begin
               state_q   <= S_CAPT;
               alu_en_q  <= 1'b0;
               alu_a_q   <= '0;
               alu_b_q   <= '0;
               alu_fun_q <= ALU_ADD;
               valE_q    <= zero_e_q ? '0 : alu_out;
               if (upd_cc_q) cc_q <= alu_cf;
               cnd_q     <= cnd_pend_q;
               done_q    <= 1'b1;
               err_q     <= ill_q;
               if (is_halt_q) halt_q <= 1'b1;
            end
            S_CAPT: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               err_q   <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy    = busy_q;
   assign alu_en  = alu_en_q;
   assign alu_a   = alu_a_q;
   assign alu_b   = alu_b_q;
   assign alu_fun = alu_fun_q;
   assign valE    = valE_q;
   assign cc      = cc_q;
   assign cnd     = cnd_q;
   assign done    = done_q;
   assign err     = err_q;
   assign halt    = halt_q;

endmodule
